banked_mem_rw: RTL and testbench
================================

Name: banked_mem_rw

Overview:
- Parametrised successor to the fixed 256x16 banked data memory: N banks x M rows, DATA_W wide.
- Write port with split high/low halves and per-half enables; independent registered read port.
- Configurable read pipeline depth, plus an automatic post-reset clear sweep.
- Sits as the multi-cycle CPU's data/program store, between the datapath's memory-address register and memory-data register.

Parameters:
- DATA_W, 16, word width; must be even (split into two DATA_W/2 halves).
- BANK_W, 3, bank-select bits; 2**BANK_W banks.
- ROW_W, 5, row-address bits per bank; 2**ROW_W rows.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  BANK_W+ROW_W  {bank, row}; bank is the MSBs.
- wr_data_hi  in  DATA_W/2  upper half of write word.
- wr_data_lo  in  DATA_W/2  lower half of write word.
- wr_be  in  2  half enables; [1]=hi, [0]=lo.
- rd_en  in  1  read request.
- rd_addr  in  BANK_W+ROW_W  {bank, row}.
- rd_data  out  DATA_W  read result.
- rd_valid  out  1  rd_data carries a valid result this cycle.
- init_busy  out  1  clear sweep in progress; requests ignored.

Behaviour:
- DEPTH = 2**(BANK_W+ROW_W) words; flat index = {bank, row}.
- Reset (async assert):
  - rd_data=0, rd_valid=0, init_busy=1.
  - FSM enters CLEAR; clear pointer = 0.
  - Pipeline valids cleared.
  - Array contents are not reset directly; they are zeroed by the sweep.
- FSM, two states:
  - CLEAR: each cycle writes 0 to word[ptr], then ptr increments. On the cycle that writes ptr=DEPTH-1, next state is READY.
  - CLEAR timing: init_busy is 1 for exactly DEPTH cycles after rst deasserts, then drops to 0.
  - READY: normal operation; stays here until the next rst.
- In CLEAR, wr_en and rd_en are ignored: no array write, no rd_valid.
- Reset asserted mid-sweep or mid-operation restarts CLEAR from ptr=0 and flushes the read pipeline.
- Write (READY, wr_en=1), at the rising edge:
  - wr_be[1]=1: word[wr_addr][DATA_W-1:DATA_W/2] <= wr_data_hi.
  - wr_be[0]=1: word[wr_addr][DATA_W/2-1:0] <= wr_data_lo.
  - wr_be=00: no change.
- Read (READY, rd_en=1) sampled at edge T:
  - RD_LAT=1: rd_data and rd_valid=1 appear after edge T (valid during cycle T+1).
  - RD_LAT=2: one extra register stage; valid during cycle T+2.
- Back-to-back reads: one result per cycle, fully pipelined, no bubbles.
- rd_valid is 0 in any cycle with no corresponding request.
- rd_data holds its last value when rd_valid=0; it is not cleared.
- Simultaneous read and write, different address: both complete normally.
- Simultaneous read and write, same address: behaviour depends on MEM_BYPASS_EN (see Optional Feature).
- Address range is exact power of two; no out-of-range case exists.
- Wrap: the clear pointer is not used after READY.

Optional Feature:
- Macro: MEM_BYPASS_EN.
- Defined: same-cycle rd_addr==wr_addr with wr_en & rd_en in READY returns the new data (write-first).
  - Halves with wr_be=1 take the write data; other halves take the stored value.
  - Forwarding is applied at the first pipeline stage, so it holds for RD_LAT=2 as well.
- Undefined: read-first; the returned word is the pre-write contents.
- Either way, the array holds the new data after the edge.

Test Plan:
- Reset then idle (defaults): init_busy=1 for 256 cycles then 0. Read every address -> 0x0000, with rd_valid exactly 1 cycle after each request.
- Full sweep: write {bank, row} to all 256 addresses (e.g. addr 0xE7 -> 0x0707), then read back pipelined, one per cycle -> every value matches, rd_valid continuous.
- Byte enables: write 0xFFFF to 0x00, then wr_be=01 with data 0x12_34 -> read 0xFF34. Then wr_be=10 with 0xAB_00 -> read 0xAB34.
- Collision at 0xFF (old 0x55AA, write 0x1234, full be):
  - MEM_BYPASS_EN defined -> read returns 0x1234.
  - Undefined -> read returns 0x55AA; next read returns 0x1234.
- RD_LAT=2: issue reads at cycles 0,1,2 to 0x0A, 0x2A, 0x4A -> results valid in cycles 2,3,4, in order.
- Reset mid-sweep at cycle 100, and again during pending reads:
  - rd_valid drops immediately.
  - init_busy stays 1 for a full 256 cycles after deassert.
  - Data previously written reads 0x0000.

Source files
------------

// File: rtl/banked_mem_rw.sv
// Banked data memory: 2**BANK_W banks x 2**ROW_W rows of DATA_W bits, half-word write enables,
// registered read with RD_LAT of 1 or 2, post-reset clear sweep. Define MEM_BYPASS_EN for write-first reads.
module banked_mem_rw #(
   parameter int DATA_W = 16,
   parameter int BANK_W = 3,
   parameter int ROW_W  = 5,
   parameter int RD_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [BANK_W+ROW_W-1:0] wr_addr,
   input  logic [DATA_W/2-1:0]     wr_data_hi,
   input  logic [DATA_W/2-1:0]     wr_data_lo,
   input  logic [1:0]              wr_be,
   input  logic                    rd_en,
   input  logic [BANK_W+ROW_W-1:0] rd_addr,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    rd_valid,
   output logic                    init_busy
);

   localparam int ADDR_W = BANK_W + ROW_W;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int HALF   = DATA_W / 2;

   typedef enum logic {CLEAR, READY} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   ptr, ptr_nxt;
   logic                wr_go, rd_go;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_word;
   logic                s1_valid;
   logic [DATA_W-1:0]   s1_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      if (state == CLEAR) begin
         ptr_nxt = ptr + 1'b1;
         if (ptr == '1)
            state_nxt = READY;
      end
   end

   assign init_busy = (state == CLEAR);
   assign wr_go     = wr_en & ~init_busy;
   assign rd_go     = rd_en & ~init_busy;

   // Array has no reset; the sweep zeroes it one word per cycle.
   always_ff @(posedge clk) begin
      if (init_busy) begin
         mem[ptr] <= '0;
      end else if (wr_go) begin
         if (wr_be[1]) mem[wr_addr][DATA_W-1:HALF] <= wr_data_hi;
         if (wr_be[0]) mem[wr_addr][HALF-1:0]      <= wr_data_lo;
      end
   end

   always_comb begin
      rd_word = mem[rd_addr];
`ifdef MEM_BYPASS_EN
      if (wr_go && (rd_addr == wr_addr)) begin
         if (wr_be[1]) rd_word[DATA_W-1:HALF] = wr_data_hi;
         if (wr_be[0]) rd_word[HALF-1:0]      = wr_data_lo;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= rd_go;
         if (rd_go)
            s1_data <= rd_word;
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              s2_valid;
         logic [DATA_W-1:0] s2_data;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_valid <= 1'b0;
               s2_data  <= '0;
            end else begin
               s2_valid <= s1_valid;
               if (s1_valid)
                  s2_data <= s1_data;
            end
         end

         assign rd_data  = s2_data;
         assign rd_valid = s2_valid;
      end else begin : g_lat1
         assign rd_data  = s1_data;
         assign rd_valid = s1_valid;
      end
   endgenerate

endmodule

// File: tb/tb_banked_mem_rw.sv
// Bench for banked_mem_rw: RD_LAT=1 and RD_LAT=2 instances driven in parallel against
// an array-plus-request-history reference model.
module tb_banked_mem_rw;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_addr = '0;
   logic [7:0]  wr_data_hi = '0;
   logic [7:0]  wr_data_lo = '0;
   logic [1:0]  wr_be = '0;
   logic        rd_en = 1'b0;
   logic [7:0]  rd_addr = '0;
   logic [15:0] rd_data1, rd_data2;
   logic        rd_valid1, rd_valid2;
   logic        busy1, busy2;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: word array plus history of (request issued, word it must return).
   logic [15:0] mem_m [256];
   bit          hv[$];
   logic [15:0] hd[$];
   logic        e_v1, e_v2;
   logic [15:0] e_d1, e_d2;

   banked_mem_rw #(.DATA_W(16), .BANK_W(3), .ROW_W(5), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data_hi(wr_data_hi), .wr_data_lo(wr_data_lo), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(busy1)
   );

   banked_mem_rw #(.DATA_W(16), .BANK_W(3), .ROW_W(5), .RD_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data_hi(wr_data_hi), .wr_data_lo(wr_data_lo), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data2), .rd_valid(rd_valid2), .init_busy(busy2)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int unsigned i = 0; i < 256; i++) mem_m[i] = 16'h0000;
      hv.delete();
      hd.delete();
      e_v1 = 1'b0; e_v2 = 1'b0;
      e_d1 = 16'h0000; e_d2 = 16'h0000;
   endtask

   // Drives one cycle of requests (device assumed ready), advances the model, returns at edge+1.
   task automatic step(input logic we, input logic [7:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input logic re, input logic [7:0] ra);
      logic [15:0] word;
      wr_en = we; wr_addr = wa; wr_data_hi = wd[15:8]; wr_data_lo = wd[7:0]; wr_be = be;
      rd_en = re; rd_addr = ra;
      @(posedge clk);
      word = mem_m[ra];
`ifdef MEM_BYPASS_EN
      if (we && re && (wa == ra)) begin
         if (be[1]) word[15:8] = wd[15:8];
         if (be[0]) word[7:0]  = wd[7:0];
      end
`endif
      if (we) begin
         if (be[1]) mem_m[wa][15:8] = wd[15:8];
         if (be[0]) mem_m[wa][7:0]  = wd[7:0];
      end
      hv.push_back(re);
      hd.push_back(word);
      if (hv.size() > 2) begin
         void'(hv.pop_front());
         void'(hd.pop_front());
      end
      e_v1 = hv[hv.size()-1];
      if (e_v1) e_d1 = hd[hd.size()-1];
      e_v2 = (hv.size() >= 2) ? hv[0] : 1'b0;
      if (e_v2) e_d2 = hd[0];
      #1;
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 8'h00);
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      n_checks++;
      if (rd_data1 !== 16'h0 || rd_valid1 !== 1'b0 || busy1 !== 1'b1 ||
          rd_data2 !== 16'h0 || rd_valid2 !== 1'b0 || busy2 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state got d=%h/%h v=%b/%b busy=%b/%b want d=0 v=0 busy=1",
                  rd_data1, rd_data2, rd_valid1, rd_valid2, busy1, busy2);
      end
      rst = 1'b0;
      model_reset();
      for (int unsigned k = 0; k <= 256; k++) begin
         if (k > 0) begin
            wr_en = 1'($urandom); rd_en = 1'($urandom); wr_be = 2'b11;
            wr_addr = 8'($urandom); rd_addr = 8'($urandom);
            wr_data_hi = 8'($urandom); wr_data_lo = 8'($urandom);
            @(posedge clk); #1;
         end
         n_checks++;
         if (busy1 !== (k < 256) || busy2 !== (k < 256) || rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_sweep cycle=%0d got busy=%b/%b v=%b/%b want busy=%b v=0",
                     k, busy1, busy2, rd_valid1, rd_valid2, (k < 256));
         end
      end
   endtask

   task automatic test_read_zero();
      for (int unsigned a = 0; a < 258; a++) begin
         if (a < 256) step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'(a));
         else idle();
         n_checks++;
         if (rd_valid1 !== e_v1 || rd_data1 !== e_d1 || rd_valid2 !== e_v2 || rd_data2 !== e_d2) begin
            n_fail++;
            $display("FAIL read_zero a=%0d got v=%b/%b d=%h/%h want v=%b/%b d=%h/%h",
                     a, rd_valid1, rd_valid2, rd_data1, rd_data2, e_v1, e_v2, e_d1, e_d2);
         end
      end
   endtask

   task automatic test_full_sweep();
      logic [7:0] a8;
      for (int unsigned a = 0; a < 256; a++) begin
         a8 = 8'(a);
         step(1'b1, a8, {5'b0, a8[7:5], 3'b0, a8[4:0]}, 2'b11, 1'b0, 8'h00);
      end
      for (int unsigned a = 0; a < 258; a++) begin
         if (a < 256) step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'(a));
         else idle();
         n_checks++;
         if (rd_valid1 !== e_v1 || rd_data1 !== e_d1 || rd_valid2 !== e_v2 || rd_data2 !== e_d2) begin
            n_fail++;
            $display("FAIL full_sweep a=%0d got v=%b/%b d=%h/%h want v=%b/%b d=%h/%h",
                     a, rd_valid1, rd_valid2, rd_data1, rd_data2, e_v1, e_v2, e_d1, e_d2);
         end
      end
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'hE7);
      n_checks++;
      if (rd_valid1 !== 1'b1 || rd_data1 !== 16'h0707) begin
         n_fail++;
         $display("FAIL sweep_e7 got v=%b d=%h want v=1 d=0707", rd_valid1, rd_data1);
      end
      idle();
   endtask

   task automatic test_lat2_order();
      logic [7:0]  addrs [3];
      logic [15:0] want  [3];
      addrs[0] = 8'h0A; addrs[1] = 8'h2A; addrs[2] = 8'h4A;
      want[0] = 16'h000A; want[1] = 16'h010A; want[2] = 16'h020A;
      for (int unsigned i = 0; i < 5; i++) begin
         if (i < 3) step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, addrs[i]);
         else idle();
         n_checks++;
         if (i >= 1 && i <= 3) begin
            if (rd_valid2 !== 1'b1 || rd_data2 !== want[i-1]) begin
               n_fail++;
               $display("FAIL lat2_order i=%0d got v=%b d=%h want v=1 d=%h", i, rd_valid2, rd_data2, want[i-1]);
            end
         end else if (rd_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat2_bubble i=%0d got v=%b want v=0", i, rd_valid2);
         end
      end
   endtask

   task automatic test_byte_enables();
      step(1'b1, 8'h00, 16'hFFFF, 2'b11, 1'b0, 8'h00);
      step(1'b1, 8'h00, 16'h1234, 2'b01, 1'b0, 8'h00);
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h00);
      idle();
      n_checks++;
      if (rd_data1 !== 16'hFF34 || rd_valid2 !== 1'b1 || rd_data2 !== 16'hFF34) begin
         n_fail++;
         $display("FAIL be_lo got d=%h/%h v2=%b want FF34", rd_data1, rd_data2, rd_valid2);
      end
      step(1'b1, 8'h00, 16'hAB00, 2'b10, 1'b0, 8'h00);
      step(1'b1, 8'h00, 16'h5555, 2'b00, 1'b0, 8'h00);
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h00);
      n_checks++;
      if (rd_valid1 !== 1'b1 || rd_data1 !== 16'hAB34) begin
         n_fail++;
         $display("FAIL be_hi got v=%b d=%h want v=1 d=AB34", rd_valid1, rd_data1);
      end
      idle();
   endtask

   task automatic test_collision();
      logic [15:0] want;
`ifdef MEM_BYPASS_EN
      want = 16'h1234;
`else
      want = 16'h55AA;
`endif
      step(1'b1, 8'hFF, 16'h55AA, 2'b11, 1'b0, 8'h00);
      step(1'b1, 8'hFF, 16'h1234, 2'b11, 1'b1, 8'hFF);
      n_checks++;
      if (rd_valid1 !== 1'b1 || rd_data1 !== want) begin
         n_fail++;
         $display("FAIL collision got v=%b d=%h want v=1 d=%h", rd_valid1, rd_data1, want);
      end
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'hFF);
      n_checks++;
      if (rd_data1 !== 16'h1234 || rd_valid2 !== 1'b1 || rd_data2 !== want) begin
         n_fail++;
         $display("FAIL collision_after got d1=%h d2=%h v2=%b want d1=1234 d2=%h",
                  rd_data1, rd_data2, rd_valid2, want);
      end
      idle();
      n_checks++;
      if (rd_data2 !== 16'h1234 || rd_valid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL collision_lat2 got d2=%h v1=%b want d2=1234 v1=0", rd_data2, rd_valid1);
      end
   endtask

   task automatic test_random();
      for (int unsigned i = 0; i < 400; i++) begin
         step(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom), 2'($urandom),
              1'($urandom), 8'($urandom_range(0, 15)));
         n_checks++;
         if (rd_valid1 !== e_v1 || rd_data1 !== e_d1 || rd_valid2 !== e_v2 || rd_data2 !== e_d2) begin
            n_fail++;
            $display("FAIL random i=%0d got v=%b/%b d=%h/%h want v=%b/%b d=%h/%h",
                     i, rd_valid1, rd_valid2, rd_data1, rd_data2, e_v1, e_v2, e_d1, e_d2);
         end
      end
   endtask

   task automatic test_mid_reset();
      rst = 1'b1; #2;
      n_checks++;
      if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0 || busy1 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_async got v=%b/%b busy=%b want v=0 busy=1", rd_valid1, rd_valid2, busy1);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (100) begin @(posedge clk); #1; end
      rst = 1'b1; #2;
      n_checks++;
      if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
         n_fail++;
         $display("FAIL midsweep_reset got busy=%b/%b want 1", busy1, busy2);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      wr_en = 1'b0; rd_en = 1'b1;
      for (int unsigned k = 1; k <= 256; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (busy1 !== (k < 256) || rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL resweep cycle=%0d got busy=%b v=%b/%b want busy=%b v=0",
                     k, busy1, rd_valid1, rd_valid2, (k < 256));
         end
      end
      step(1'b1, 8'h33, 16'hBEEF, 2'b11, 1'b0, 8'h00);
      step(1'b1, 8'h44, 16'hCAFE, 2'b11, 1'b0, 8'h00);
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h33);
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h44);
      rst = 1'b1; #2;
      n_checks++;
      if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0 || rd_data1 !== 16'h0 || rd_data2 !== 16'h0) begin
         n_fail++;
         $display("FAIL pending_reset got v=%b/%b d=%h/%h want v=0 d=0", rd_valid1, rd_valid2, rd_data1, rd_data2);
      end
      @(posedge clk); #1;
      rst = 1'b0; rd_en = 1'b0;
      model_reset();
      repeat (256) begin @(posedge clk); #1; end
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h33);
      step(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h44);
      n_checks++;
      if (busy1 !== 1'b0 || rd_valid1 !== 1'b1 || rd_data1 !== 16'h0 || rd_valid2 !== 1'b1 || rd_data2 !== 16'h0) begin
         n_fail++;
         $display("FAIL cleared_data got busy=%b v=%b/%b d=%h/%h want busy=0 v=1 d=0",
                  busy1, rd_valid1, rd_valid2, rd_data1, rd_data2);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_read_zero();
      test_full_sweep();
      test_lat2_order();
      test_byte_enables();
      test_collision();
      test_random();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
